// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between the multicycle controller and its datapath
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic [1:0] npc_op;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pc_wr, ir_wr, rf_wr, dm_wr, npc_op, ext_op, alu_op, alu_src,
               reg_dst, mem_to_reg, state, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, ir_wr, rf_wr, dm_wr, npc_op, ext_op, alu_op, alu_src,
               reg_dst, mem_to_reg, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM; CTRL_JR_EN enables jr
module multicycle_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
`ifdef CTRL_JR_EN
    localparam logic [5:0] FN_JR    = 6'b001000;
`endif

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;

    // MEM counts down from MEM_LAT-1 to 0, so the state lasts exactly MEM_LAT cycles
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

    logic pc_wr_c, ir_wr_c, rf_wr_c, dm_wr_c, illegal_c;
    logic [1:0] npc_op_c;

    assign is_rtype = (bus.op == OP_RTYPE);
    assign is_addu  = is_rtype && (bus.funct == FN_ADDU);
    assign is_subu  = is_rtype && (bus.funct == FN_SUBU);
`ifdef CTRL_JR_EN
    assign is_jr    = is_rtype && (bus.funct == FN_JR);
`else
    assign is_jr    = 1'b0;
`endif
    assign is_ori   = (bus.op == OP_ORI);
    assign is_lui   = (bus.op == OP_LUI);
    assign is_lw    = (bus.op == OP_LW);
    assign is_sw    = (bus.op == OP_SW);
    assign is_beq   = (bus.op == OP_BEQ);
    assign is_j     = (bus.op == OP_J);
    assign is_jal   = (bus.op == OP_JAL);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = is_legal ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    cnt_d   = CNT_LOAD;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        rf_wr_c   = 1'b0;
        dm_wr_c   = 1'b0;
        illegal_c = 1'b0;
        npc_op_c  = NPC_SEQ;
        case (state_q)
            S_FETCH: begin
                pc_wr_c = 1'b1;
                ir_wr_c = 1'b1;
            end
            S_DECODE: illegal_c = !is_legal;
            S_EXEC: begin
                if (is_beq) begin
                    pc_wr_c  = bus.zero;
                    npc_op_c = NPC_BR;
                end else if (is_j || is_jal) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = NPC_JMP;
                    rf_wr_c  = is_jal;
                end else if (is_jr) begin
                    pc_wr_c  = 1'b1;
                    npc_op_c = NPC_REG;
                end
            end
            S_MEM:   dm_wr_c = is_sw;
            S_WB:    rf_wr_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath selects follow the opcode in every state; only strobes depend on state
    always_comb begin
        bus.ext_op     = 2'b10;
        bus.alu_op     = 3'b000;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 2'b00;
        if (is_ori) begin
            bus.ext_op  = 2'b01;
            bus.alu_op  = 3'b010;
            bus.alu_src = 1'b1;
        end else if (is_lui) begin
            bus.ext_op  = 2'b00;
            bus.alu_op  = 3'b011;
            bus.alu_src = 1'b1;
        end else if (is_lw || is_sw) begin
            bus.alu_src    = 1'b1;
            bus.mem_to_reg = is_lw ? 2'b01 : 2'b00;
        end else if (is_beq) begin
            bus.alu_op = 3'b001;
        end else if (is_jal) begin
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b10;
        end else if (is_rtype) begin
            bus.reg_dst = 2'b01;
            bus.alu_op  = is_subu ? 3'b001 : 3'b000;
        end
    end

    // Strobes are masked directly by rst_n so an aborted instruction writes nothing
    assign bus.pc_wr   = rst_n & pc_wr_c;
    assign bus.ir_wr   = rst_n & ir_wr_c;
    assign bus.rf_wr   = rst_n & rf_wr_c;
    assign bus.dm_wr   = rst_n & dm_wr_c;
    assign bus.illegal = rst_n & illegal_c;
    assign bus.npc_op  = npc_op_c;
    assign bus.state   = state_q;
endmodule
